uart_packet_tx: RTL and testbench

UART_PACKET_TX -- requirements
Module: uart_packet_tx

---
 rtl/dds_uart_pkg.sv | 38 +++
 rtl/uart_tx_byte.sv | 113 +++++++++++
 rtl/uart_packet_tx.sv | 120 ++++++++++++
 tb/tb_uart_packet_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dds_uart_pkg.sv
// Shared constants for the DDS control link. The transmit side (uart_packet_tx)
// and the receive-side packet parser both build and recognise frames from these.
//   Frame layout, 7 bytes: PKT_HEADER, cmd, payload[31:24], payload[23:16],
//   payload[15:8], payload[7:0], PKT_FOOTER.
package dds_uart_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hAA;
  localparam logic [7:0] PKT_FOOTER = 8'h55;
  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam int         PKT_BYTES  = 7;

  // Index of the final byte in a frame; the byte index is 3 bits wide.
  localparam logic [2:0] LAST_BYTE_IDX = 3'(PKT_BYTES - 1);

  // One latched frame request.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] payload;
  } pkt_req_t;

  // Byte at position idx of a frame; the payload goes out most significant byte first.
  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [7:0]  cmd,
                                          input logic [31:0] payload);
    logic [7:0] b;
    case (idx)
      3'd0:    b = PKT_HEADER;
      3'd1:    b = cmd;
      3'd2:    b = payload[31:24];
      3'd3:    b = payload[23:16];
      3'd4:    b = payload[15:8];
      3'd5:    b = payload[7:0];
      default: b = PKT_FOOTER;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
//   clk, rst     : system clock, asynchronous active-high reset
//   byte_valid   : a byte is offered on byte_data
//   byte_data    : byte to send, LSB first
//   byte_ready   : the offered byte is accepted on this edge (idle, or last
//                  cycle of a stop bit so bytes chain with no idle time)
//   byte_done    : last cycle of a stop bit
//   tx           : serial line, driven straight from a flop, idle high
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START_BIT = 2'd1;
  localparam logic [1:0] S_DATA_BITS = 2'd2;
  localparam logic [1:0] S_STOP_BIT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end    = (baud_q == CNT_LAST);
  assign byte_done  = (state_q == S_STOP_BIT) && bit_end;
  assign byte_ready = (state_q == S_IDLE) || byte_done;
  assign tx         = tx_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;

    // Baud counter free-runs while a byte is on the line and reloads at each bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          state_d = S_START_BIT;
          data_d  = byte_data;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      S_START_BIT: begin
        if (bit_end) begin
          state_d   = S_DATA_BITS;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end
      end
      S_DATA_BITS: begin
        if (bit_end) begin
          // 3-bit index wraps 7 -> 0 as the last data bit finishes.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            tx_d = data_q[bit_idx_q + 3'd1];
          end
        end
      end
      default: begin // S_STOP_BIT
        if (bit_end) begin
          if (byte_valid) begin
            // Next byte's start bit follows the stop bit directly.
            state_d = S_START_BIT;
            data_d  = byte_data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Sends a 7-byte DDS command frame (header, cmd, 32-bit payload big-endian,
// footer) over a UART line, 8N1, bytes back-to-back.
//   clk, rst : system clock, asynchronous active-high reset
//   start    : one-cycle request; sampled only while idle
//   cmd      : command byte, latched with start
//   payload  : data word, latched with start
//   busy     : frame in flight (set on the accepting edge, cleared after done)
//   done     : one-cycle pulse once the last stop bit has completed
//   tx       : serial line, idle high
module uart_packet_tx
  import dds_uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] payload,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_SEND = 2'd1;
  localparam logic [1:0] F_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  pkt_req_t   req_q, req_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_done;

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    req_d      = req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_valid = 1'b0;
    byte_data  = PKT_HEADER;

    case (state_q)
      F_IDLE: begin
        // The header is offered straight from the start request so the start
        // bit appears on the very next cycle.
        byte_valid = start;
        if (start && byte_ready) begin
          state_d    = F_SEND;
          byte_idx_d = 3'd0;
          req_d      = '{cmd: cmd, payload: payload};
          busy_d     = 1'b1;
        end
      end
      F_SEND: begin
        // byte_idx_q is the byte on the line; the following one is kept on
        // offer so the serializer takes it at the end of the current stop bit.
        byte_valid = (byte_idx_q != LAST_BYTE_IDX);
        byte_data  = pkt_byte(byte_idx_q + 3'd1, req_q.cmd, req_q.payload);
        if (byte_done) begin
          if (byte_idx_q == LAST_BYTE_IDX) begin
            state_d = F_DONE;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      F_DONE: begin
        state_d = F_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = F_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      byte_idx_q <= 3'd0;
      req_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .byte_done  (byte_done),
    .tx         (tx)
  );

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx at a reduced bit period (13 clocks per bit) so many
// frames fit in a short run. Expected line levels come from the frame rule
// {AA, cmd, payload big-endian, 55} expanded into 8N1 bits; a UART decoder
// recovers the bytes independently.
module tb_uart_packet_tx;

  localparam int CLK_FREQ  = 1497600;
  localparam int BAUD_RATE = 115200;
  localparam int C         = CLK_FREQ / BAUD_RATE; // 13 clocks per bit
  localparam int FRAME     = 70 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd = 8'd0;
  logic [31:0] payload = 32'd0;
  logic        busy, done, tx;

  uart_packet_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .payload (payload),
    .busy    (busy),
    .done    (done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  time t_end = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] payload;
    logic [55:0] exp_frame;
    bit          spam;
    bit          b2b;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line level during bit b (0..69) of a frame.
  function automatic logic exp_bit(input logic [55:0] f, input int b);
    int         j;
    int         pos;
    logic [7:0] by;
    j   = b / 10;
    pos = b % 10;
    by  = f[55 - 8*j -: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos-1];
  endfunction

  // Mid-bit sampling UART receiver.
  logic [7:0] rx_q[$];
  int         framing_err = 0;

  initial begin : decoder
    logic [7:0] b;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        repeat (C/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (tx !== 1'b1) framing_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic run_frame(input int id, input logic [7:0] c, input logic [31:0] p,
                           input logic [55:0] expf, input bit spam, input bit b2b);
    int wave_err, busy_err, done_err, req_cycles, gap;
    wave_err = 0; busy_err = 0; done_err = 0; req_cycles = 0; gap = 0;
    if (!b2b) @(negedge clk);
    start = 1'b1; cmd = c; payload = p;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      req_cycles++;
      if (k == 0 && b2b) begin
        gap = int'(($time - t_end) / 10);
        total++;
        if (gap > 2) begin
          bad++;
          $display("FAIL gap_%0d: got %0d idle cycles, required at most 2", id, gap);
        end
      end
      // Scramble inputs after the accepting edge; optionally re-request mid-frame.
      start   = (spam && (k % 100) == 50);
      cmd     = 8'($urandom);
      payload = $urandom;
      if (tx !== exp_bit(expf, k / C)) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
    end
    start = 1'b0;
    chk($sformatf("wave_%0d", id), wave_err, 0);
    chk($sformatf("busy_in_frame_%0d", id), busy_err, 0);
    chk($sformatf("done_in_frame_%0d", id), done_err, 0);
    @(negedge clk);
    req_cycles++;
    t_end = $time;
    chk($sformatf("done_pulse_%0d", id), longint'(done), 1);
    chk($sformatf("busy_at_done_%0d", id), longint'(busy), 1);
    chk($sformatf("tx_at_done_%0d", id), longint'(tx), 1);
    @(negedge clk);
    req_cycles++;
    chk($sformatf("done_cleared_%0d", id), longint'(done), 0);
    chk($sformatf("busy_cleared_%0d", id), longint'(busy), 0);
    chk($sformatf("req_to_idle_%0d", id), req_cycles, FRAME + 2);
    chk($sformatf("rx_count_%0d", id), rx_q.size(), 7);
    for (int j = 0; j < 7; j++) begin
      logic [7:0] got;
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      chk($sformatf("rx_byte_%0d_%0d", id, j), longint'(got), longint'(expf[55 - 8*j -: 8]));
    end
    $display("frame %0d cmd=%02h payload=%08h rx_bytes=%0d gap=%0d spam=%0d",
             id, c, p, rx_q.size(), gap, spam);
    rx_q.delete();
  endtask

  initial begin : main
    int quiet_err;
    logic [7:0]  rc;
    logic [31:0] rp;

    vecs[0] = '{8'h01, 32'h028F5C28, 56'hAA01028F5C2855, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 32'hFFFFFFFF, 56'hAAFFFFFFFFFF55, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 32'h00000000, 56'hAA000000000055, 1'b0, 1'b1};
    for (int i = 3; i < 7; i++) begin
      rc = 8'($urandom);
      rp = $urandom;
      vecs[i] = '{rc, rp, {8'hAA, rc, rp, 8'h55}, 1'b0, (i == 5)};
    end

    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_tx", longint'(tx), 1);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("reset released");

    for (int i = 0; i < 7; i++) begin
      run_frame(i, vecs[i].cmd, vecs[i].payload, vecs[i].exp_frame, vecs[i].spam, vecs[i].b2b);
    end

    // Abort a frame during the start bit of byte 1, with reset asserted mid-cycle.
    @(negedge clk);
    start = 1'b1; cmd = 8'h01; payload = 32'h12345678;
    for (int n = 1; n <= 10*C + 2; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_tx_low", longint'(tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_immediate", longint'(tx), 1);
    chk("rst_busy_immediate", longint'(busy), 0);
    chk("rst_done_immediate", longint'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_err = 0;
    for (int n = 0; n < 20*C; n++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet_err++;
    end
    chk("post_rst_quiet", quiet_err, 0);
    $display("reset abort quiet_cycles=%0d disturbances=%0d", 20*C, quiet_err);
    rx_q.delete();
    rc = 8'h01;
    rp = $urandom;
    run_frame(7, rc, rp, {8'hAA, rc, rp, 8'h55}, 1'b0, 1'b0);

    chk("framing_errors", framing_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
